// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer.
package mole_pkg;

  localparam int unsigned RNG_W     = 8;
  localparam int unsigned TIMER_W   = 16;
  localparam int unsigned DELAY_LSB = 0;
  localparam int unsigned DELAY_W   = 4;
  localparam int unsigned IDX_LSB   = 0;
  localparam int unsigned IDX_W     = 3;

  typedef enum logic [2:0] {
    StIdle,
    StDrawWait,
    StLoadWait,
    StWait,
    StDrawMole,
    StLoadMole,
    StShow,
    StNext
  } state_e;

endpackage

// File: rtl/mole_scheduler_if.sv
// Game-side signal bundle of mole_scheduler: RNG, buttons, LEDs and score.
interface mole_scheduler_if import mole_pkg::*; #(
  parameter int unsigned NUM_MOLES = 4
);
  logic                 tick;
  logic                 start;
  logic [RNG_W-1:0]     rnd;
  logic [NUM_MOLES-1:0] btn;
  logic                 rng_en;
  logic [NUM_MOLES-1:0] mole;
  logic                 hit;
  logic                 miss;
  logic [7:0]           score;
  logic                 busy;
  logic                 done;

  modport master (
    output tick, start, rnd, btn,
    input  rng_en, mole, hit, miss, score, busy, done
  );

  modport slave (
    input  tick, start, rnd, btn,
    output rng_en, mole, hit, miss, score, busy, done
  );
endinterface

// File: rtl/mole_scheduler_tick_timer.sv
// Loadable down-counter stepped by the timebase tick; expire fires on the 1->0 tick.
module tick_timer import mole_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  input  logic               tick,
  output logic               expire
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  assign expire = en && tick && !load && (cnt_q == TIMER_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer: draws delays/moles from the RNG, judges presses, keeps score.
// Optional MOLE_NO_REPEAT_EN: never light the same mole in two consecutive rounds.
module mole_scheduler import mole_pkg::*; #(
  parameter int unsigned NUM_MOLES  = 4,
  parameter int unsigned ROUNDS     = 16,
  parameter int unsigned WAIT_BASE  = 4,
  parameter int unsigned SHOW_TICKS = 20
) (
  input logic              clk,
  input logic              rst,
  mole_scheduler_if.slave  bus
);

  state_e               state_q, state_d;
  logic [7:0]           round_q, round_d;
  logic [7:0]           score_q, score_d;
  logic [NUM_MOLES-1:0] mole_q, mole_d;
  logic                 rng_en_q, rng_en_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

`ifdef MOLE_NO_REPEAT_EN
  logic [IDX_W-1:0]     prev_q, prev_d;
  logic                 prev_vld_q, prev_vld_d;
`endif

  logic                 tmr_load;
  logic [TIMER_W-1:0]   tmr_val;
  logic                 tmr_en;
  logic                 expire;
  logic [IDX_W-1:0]     cand;
  logic                 cand_ok;
  logic                 wrong_press;
  logic                 right_press;
  logic                 unused_rnd;

  assign cand        = bus.rnd[IDX_LSB +: IDX_W];
  assign unused_rnd  = ^bus.rnd[RNG_W-1:DELAY_W];
  assign wrong_press = |(bus.btn & ~mole_q);
  assign right_press = |(bus.btn & mole_q);
  assign tmr_en      = (state_q == StWait) || (state_q == StShow);

  always_comb begin
    cand_ok = (32'(cand) < NUM_MOLES);
`ifdef MOLE_NO_REPEAT_EN
    if (prev_vld_q && (prev_q == cand)) cand_ok = 1'b0;
`endif
  end

  tick_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .tick     (bus.tick),
    .expire   (expire)
  );

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    score_d  = score_q;
    mole_d   = mole_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef MOLE_NO_REPEAT_EN
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StDrawWait;
          score_d = '0;
          round_d = 8'(ROUNDS);
          busy_d  = 1'b1;
`ifdef MOLE_NO_REPEAT_EN
          prev_vld_d = 1'b0;
`endif
        end
      end
      StDrawWait: state_d = StLoadWait;
      StLoadWait: begin
        tmr_load = 1'b1;
        tmr_val  = TIMER_W'(WAIT_BASE) + TIMER_W'(bus.rnd[DELAY_LSB +: DELAY_W]);
        state_d  = StWait;
      end
      StWait: begin
        if (expire) state_d = StDrawMole;
      end
      StDrawMole: state_d = StLoadMole;
      StLoadMole: begin
        // Out-of-range (or repeated) candidates cost another draw.
        if (cand_ok) begin
          mole_d   = NUM_MOLES'(1) << cand;
          tmr_load = 1'b1;
          tmr_val  = TIMER_W'(SHOW_TICKS);
          state_d  = StShow;
`ifdef MOLE_NO_REPEAT_EN
          prev_d     = cand;
          prev_vld_d = 1'b1;
`endif
        end else begin
          state_d = StDrawMole;
        end
      end
      StShow: begin
        if (wrong_press) begin
          miss_d  = 1'b1;
          state_d = StNext;
        end else if (right_press) begin
          hit_d   = 1'b1;
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          state_d = StNext;
        end else if (expire) begin
          miss_d  = 1'b1;
          state_d = StNext;
        end
      end
      StNext: begin
        mole_d  = '0;
        round_d = round_q - 8'd1;
        if (round_d == 8'd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          state_d = StDrawWait;
        end
      end
    endcase

    rng_en_d = (state_d == StDrawWait) || (state_d == StDrawMole);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      round_q  <= '0;
      score_q  <= '0;
      mole_q   <= '0;
      rng_en_q <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MOLE_NO_REPEAT_EN
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      score_q  <= score_d;
      mole_q   <= mole_d;
      rng_en_q <= rng_en_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MOLE_NO_REPEAT_EN
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
`endif
    end
  end

  assign bus.rng_en = rng_en_q;
  assign bus.mole   = mole_q;
  assign bus.hit    = hit_q;
  assign bus.miss   = miss_q;
  assign bus.score  = score_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: table of rounds plus reset/multi-cycle sequences, judge scoreboard.
`timescale 1ns/1ps
module tb_mole_scheduler;
  import mole_pkg::*;

  localparam int unsigned NM = 4;
  localparam int unsigned NR = 4;
  localparam int unsigned WB = 4;
  localparam int unsigned ST = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mole_scheduler_if #(.NUM_MOLES(NM)) bus ();

  mole_scheduler #(
    .NUM_MOLES  (NM),
    .ROUNDS     (NR),
    .WAIT_BASE  (WB),
    .SHOW_TICKS (ST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] rnd_wait;
    logic [7:0] c0;
    logic [7:0] c1;
    int         ncand;
    int         exp_wait;
    int         exp_draws;
    logic [3:0] exp_mole;
    int         idle_ticks;
    logic [3:0] btn;
    logic       final_tick;
    logic       exp_hit;
    logic       wait_noise;
  } round_t;

  typedef struct packed {
    logic       hit;
    logic       miss;
    logic [7:0] score;
  } ev_t;

  round_t     tbl [9];
  logic [7:0] rnd_q [$];
  ev_t        sb_q [$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         exp_score = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RNG stand-in: each rng_en pulse presents the next queued value.
  initial begin
    logic prev_rng;
    prev_rng = 1'b0;
    bus.rnd  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.rng_en === 1'b1) begin
        check("rng_en_single_cycle", {31'd0, prev_rng}, 32'd0);
        bus.rnd = (rnd_q.size() > 0) ? rnd_q.pop_front() : 8'h00;
      end
      prev_rng = (bus.rng_en === 1'b1);
    end
  end

  // Judge monitor: every hit/miss pulse must match the next expected event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (bus.hit === 1'b1 || bus.miss === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_judge", {30'd0, bus.hit, bus.miss}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("judge_hit", {31'd0, bus.hit}, {31'd0, e.hit});
          check("judge_miss", {31'd0, bus.miss}, {31'd0, e.miss});
          check("judge_score", {24'd0, bus.score}, {24'd0, e.score});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic start_game();
    exp_score = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("start_busy", {31'd0, bus.busy}, 32'd1);
    check("start_score_clear", {24'd0, bus.score}, 32'd0);
  endtask

  task automatic run_round(input round_t r, input bit last, input bit stop_in_show);
    int k;
    int cnt;
    int draws;
    ev_t e;
    rnd_q.push_back(r.rnd_wait);
    rnd_q.push_back(r.c0);
    if (r.ncand > 1) rnd_q.push_back(r.c1);

    k = 0;
    while (bus.rng_en !== 1'b1 && k < 8) begin
      step();
      k++;
    end
    check("draw_wait_pulse", {31'd0, bus.rng_en}, 32'd1);
    step();
    // Tick during LOAD_WAIT must not count.
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    cnt = 0;
    k   = 0;
    while (k < 64) begin
      bus.tick = 1'b1;
      if (r.wait_noise && cnt == 1) begin
        bus.btn   = 4'b1111;
        bus.start = 1'b1;
      end
      step();
      bus.tick  = 1'b0;
      bus.btn   = '0;
      bus.start = 1'b0;
      cnt++;
      if (bus.rng_en === 1'b1) break;
      step();
      if (bus.rng_en === 1'b1) break;
      k++;
    end
    check("wait_ticks", cnt, r.exp_wait);
    check("draw_mole_pulse", {31'd0, bus.rng_en}, 32'd1);

    draws = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.mole !== 4'b0000) break;
      if (bus.rng_en === 1'b1) draws++;
    end
    check("mole_draws", draws, r.exp_draws);
    check("mole_lit", {28'd0, bus.mole}, {28'd0, r.exp_mole});
    if (stop_in_show) return;

    for (int i = 0; i < r.idle_ticks; i++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      step();
    end
    if (r.exp_hit) exp_score++;
    e.hit   = r.exp_hit;
    e.miss  = !r.exp_hit;
    e.score = 8'(exp_score);
    sb_q.push_back(e);
    bus.btn  = r.btn;
    bus.tick = r.final_tick;
    step();
    bus.btn  = '0;
    bus.tick = 1'b0;
    check("mole_held_in_next", {28'd0, bus.mole}, {28'd0, r.exp_mole});
    step();
    check("mole_cleared", {28'd0, bus.mole}, 32'd0);
    check("done_pulse", {31'd0, bus.done}, {31'd0, last});
    check("busy_level", {31'd0, bus.busy}, {31'd0, !last});
    if (last) begin
      check("final_score", {24'd0, bus.score}, exp_score);
      step();
      check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    end
  endtask

  initial begin
    //           wait   c0     c1     n  wait draws mole     idle btn      ft  hit noise
    tbl[0] = '{8'h05, 8'h06, 8'h02, 2, 9,  2, 4'b0100, 19, 4'b0100, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{8'h0F, 8'h01, 8'h00, 1, 19, 1, 4'b0010, 3,  4'b0010, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{8'h00, 8'h02, 8'h00, 1, 4,  1, 4'b0100, 0,  4'b0101, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'h13, 8'h0B, 8'h00, 1, 7,  1, 4'b1000, 19, 4'b0000, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 8'h03, 8'h00, 1, 5,  1, 4'b1000, 0,  4'b1000, 1'b0, 1'b1, 1'b0};
`ifdef MOLE_NO_REPEAT_EN
    tbl[5] = '{8'h02, 8'h03, 8'h01, 2, 6,  2, 4'b0010, 2,  4'b0010, 1'b0, 1'b1, 1'b0};
`else
    tbl[5] = '{8'h02, 8'h03, 8'h00, 1, 6,  1, 4'b1000, 2,  4'b1000, 1'b0, 1'b1, 1'b0};
`endif
    tbl[6] = '{8'h0A, 8'h00, 8'h00, 1, 14, 1, 4'b0001, 1,  4'b0001, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'h04, 8'h01, 8'h00, 1, 8,  1, 4'b0010, 0,  4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{8'h03, 8'h01, 8'h00, 1, 7,  1, 4'b0010, 0,  4'b0010, 1'b0, 1'b1, 1'b0};

    rst       = 1'b1;
    bus.tick  = 1'b0;
    bus.start = 1'b0;
    bus.btn   = '0;
    repeat (3) step();
    check("rst_rng_en", {31'd0, bus.rng_en}, 32'd0);
    check("rst_mole", {28'd0, bus.mole}, 32'd0);
    check("rst_hit_miss", {30'd0, bus.hit, bus.miss}, 32'd0);
    check("rst_score", {24'd0, bus.score}, 32'd0);
    check("rst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_busy", {31'd0, bus.busy}, 32'd0);

    start_game();
    for (int i = 0; i < 4; i++) run_round(tbl[i], (i == 3), 1'b0);

    start_game();
    for (int i = 4; i < 7; i++) run_round(tbl[i], 1'b0, 1'b0);
    run_round(tbl[7], 1'b0, 1'b1);
    check("pre_reset_mole", {28'd0, bus.mole}, 32'b0010);
    check("pre_reset_score", {24'd0, bus.score}, 32'd3);
    rst = 1'b1;
    step();
    check("abort_mole", {28'd0, bus.mole}, 32'd0);
    check("abort_score", {24'd0, bus.score}, 32'd0);
    check("abort_flags", {27'd0, bus.busy, bus.done, bus.hit, bus.miss, bus.rng_en}, 32'd0);
    rst = 1'b0;
    step();
    check("post_reset_idle", {27'd0, bus.busy, bus.done, bus.hit, bus.miss, bus.rng_en}, 32'd0);
    start_game();
    run_round(tbl[8], 1'b0, 1'b0);
    check("fresh_game_score", {24'd0, bus.score}, 32'd1);

    repeat (2) step();
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Game-round sequencer for Whack-a-mole that owns the 8-bit pseudo-random generator. It steps the generator, then uses the drawn values to set a random idle delay and pick which mole lights. It opens a timed whack window, judges button presses as hit or miss, and keeps score over a fixed number of rounds. It sits between the RNG, the debounced button inputs and the LED/score display logic.

## Interface
- NUM_MOLES, 4: number of moles/buttons, legal range 2..8
- ROUNDS, 16: rounds per game, 1..255
- WAIT_BASE, 4: minimum idle delay in ticks, ≥1
- SHOW_TICKS, 20: whack-window length in ticks, ≥1
- clk  in  1  system clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-cycle timebase pulse (e.g. 1 ms)
- start  in  1  one-cycle pulse requesting a new game
- rnd  in  8  current RNG state
- btn  in  NUM_MOLES  debounced one-cycle press pulses, bit i = mole i
- rng_en  out  1  one-cycle pulse; advances the RNG one step
- mole  out  NUM_MOLES  one-hot lit mole, all-zero when none
- hit  out  1  one-cycle pulse, correct whack
- miss  out  1  one-cycle pulse, wrong button or timeout
- score  out  8  hits in the current game
- busy  out  1  high from game accept until the game ends
- done  out  1  one-cycle pulse when the last round finishes

## Operation
- All outputs are registered. Reset value of every output is 0. Internal state returns to IDLE; the round counter, timer and previous-mole register clear.
- States: IDLE, DRAW_WAIT, LOAD_WAIT, WAIT, DRAW_MOLE, LOAD_MOLE, SHOW, NEXT.
- IDLE: `start` moves the block to DRAW_WAIT. On the same edge, `score` clears, the round counter loads ROUNDS and `busy` sets. `start` is ignored in every other state.
- DRAW_WAIT: `rng_en`=1 for this one cycle, then go to LOAD_WAIT.
- LOAD_WAIT: timer ← WAIT_BASE + rnd[3:0], zero-extended. The timer is wide enough for the sum. Go to WAIT.
- WAIT: each `tick` decrements the timer. On the tick that takes it from 1 to 0, go to DRAW_MOLE. Button presses in WAIT are ignored.
- DRAW_MOLE: `rng_en`=1 for one cycle, then go to LOAD_MOLE.
- LOAD_MOLE: candidate = rnd[2:0].
  - If candidate ≥ NUM_MOLES, reject it and return to DRAW_MOLE.
  - Otherwise, latch the index, set the `mole` one-hot, load timer ← SHOW_TICKS and go to SHOW.
- SHOW: judging rules, in priority order:
  - If any `btn` bit outside the lit mole is set, pulse `miss` and go to NEXT. A wrong press outranks a correct press in the same cycle.
  - Else if the lit mole's `btn` bit is set, pulse `hit`, increment `score` (saturating at 255) and go to NEXT. A hit outranks a timeout in the same cycle.
  - Else on the tick that takes the timer from 1 to 0, pulse `miss` and go to NEXT.
- NEXT: `mole` ← 0 and the round counter decrements.
  - If it reaches 0, pulse `done`, clear `busy` and go to IDLE.
  - Otherwise go to DRAW_WAIT.
- `rst` asserted in any state aborts the game immediately, with no `done` or `miss` pulse.

## Timing
- `rng_en` is high for exactly one cycle per draw. `rnd` is sampled in the following cycle (RNG updates on the `rng_en` edge).
- Draw-to-decision latency is 2 cycles per attempt; each rejection adds 2 cycles.
- Exactly N `tick` pulses elapse in WAIT/SHOW for a loaded timer value N. Ticks outside WAIT/SHOW are ignored.
- `mole` rises on the edge leaving LOAD_MOLE and falls on the edge leaving NEXT.
- `hit` and `miss` assert on the edge leaving SHOW.
- `done` asserts one cycle after the final `hit`/`miss`. `busy` falls on the same edge as `done`.

## Configuration
- MOLE_NO_REPEAT_EN defined: LOAD_MOLE also rejects a candidate equal to the previously lit mole, so the same mole never lights twice in a row. The previous-mole register is invalid after reset and after each `start`.
- MOLE_NO_REPEAT_EN undefined: only the range check applies, and no previous-mole register is built.

## Structure
- Package mole_pkg holds:
  - the state enum
  - the RNG width constant (8)
  - the timer width constant
  - the field positions rnd[3:0] (delay) and rnd[2:0] (mole index)
- One sub-module, tick_timer: a loadable down-counter that decrements on `tick` and emits an `expire` strobe on the 1→0 transition. It is used for both WAIT and SHOW.

## Test plan
- Reset mid-SHOW, with `mole`=0010 and `score`=3 → all outputs 0 on the next cycle; a later `start` begins a fresh game with `score`=0.
- `start` with rnd[3:0]=5 and WAIT_BASE=4 at LOAD_WAIT → exactly 9 ticks in WAIT, then `rng_en` pulses once.
- NUM_MOLES=4, rnd[2:0]=6 then 2 on successive draws → two `rng_en` pulses, then `mole`=0100.
- In SHOW with mole 2 lit, `btn`=0100 and the timer-expiring tick in the same cycle → `hit`=1, `miss`=0, `score`+1.
- `btn`=0101 with mole 2 lit → `miss`=1, `score` unchanged; with no press for SHOW_TICKS=20 ticks → `miss` on the 20th tick.
- ROUNDS=2 with MOLE_NO_REPEAT_EN defined, and rnd[2:0] yielding 1, 1, 3 → mole 1, then one rejection, then mole 3; `done` pulses after the second round and `busy` falls with it.
